// File: rtl/lsu_dccm_arb_pkg.sv
// Shared types for the DCCM single-port arbiter: read-response owner tags,
// the selected write request, and the DMA age counter width.
package lsu_dccm_arb_pkg;

  localparam int DCCM_ARB_AGE_W  = 3;
  localparam int DCCM_ARB_ADDR_W = 16;
  localparam int DCCM_ARB_DATA_W = 39;

  // Owner of the read issued last cycle; selects which response port is valid.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_DMA  = 2'd2
  } dccm_owner_e;

  // One memory write request as selected by the arbiter.
  typedef struct packed {
    logic [DCCM_ARB_ADDR_W-1:0] addr;
    logic [DCCM_ARB_DATA_W-1:0] data;
    logic                       write;
  } dccm_req_t;

endpackage

// File: rtl/lsu_dccm_arb_age.sv
// DMA anti-starvation counter: counts cycles in which DMA waits ungranted,
// saturates, and raises dma_force once it reaches the age limit.
// Only instantiated when LSU_DCCM_ARB_AGING_EN is defined.
module lsu_dccm_arb_age
  import lsu_dccm_arb_pkg::*;
#(
  parameter int AGE_MAX = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic dma_force
);

  localparam logic [DCCM_ARB_AGE_W-1:0] AGE_LIMIT = DCCM_ARB_AGE_W'(AGE_MAX);

  logic [DCCM_ARB_AGE_W-1:0] dma_age_q;

  // Age counter: clear on grant, count up (saturating) while DMA waits.
  always_ff @(posedge clk) begin
    if (rst || dma_gnt) begin
      dma_age_q <= '0;
    end else if (dma_req && (dma_age_q != AGE_LIMIT)) begin
      dma_age_q <= dma_age_q + 1'b1;
    end
  end

  assign dma_force = (dma_age_q == AGE_LIMIT);

endmodule

// File: rtl/lsu_dccm_arb.sv
// Single-port DCCM arbiter between LSU loads, store-buffer drains and DMA.
// Grants at most one access per cycle, drives the memory port, and tags the
// one-cycle read return to its owner.
// Optional feature macro: LSU_DCCM_ARB_AGING_EN (DMA aging / forced priority).
module lsu_dccm_arb
  import lsu_dccm_arb_pkg::*;
#(
  parameter int DCCM_BITS   = 16,
  parameter int FDATA_WIDTH = 39,
  parameter int AGE_MAX     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu_freeze_dc3,
  input  logic                   lsu_rd_req,
  input  logic [DCCM_BITS-1:0]   lsu_rd_addr_lo,
  input  logic [DCCM_BITS-1:0]   lsu_rd_addr_hi,
  output logic                   lsu_rd_gnt,
  input  logic                   sb_wr_req,
  input  logic                   sb_full,
  input  logic [DCCM_BITS-1:0]   sb_wr_addr,
  input  logic [FDATA_WIDTH-1:0] sb_wr_data,
  output logic                   sb_wr_gnt,
  input  logic                   dma_req,
  input  logic                   dma_write,
  input  logic [DCCM_BITS-1:0]   dma_addr,
  input  logic [FDATA_WIDTH-1:0] dma_wr_data,
  output logic                   dma_gnt,
  output logic                   dccm_wren,
  output logic                   dccm_rden,
  output logic [DCCM_BITS-1:0]   dccm_wr_addr,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_hi,
  output logic [FDATA_WIDTH-1:0] dccm_wr_data,
  input  logic [FDATA_WIDTH-1:0] dccm_rd_data_lo,
  input  logic [FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic                   lsu_rsp_valid,
  output logic [FDATA_WIDTH-1:0] lsu_rsp_data_lo,
  output logic [FDATA_WIDTH-1:0] lsu_rsp_data_hi,
  output logic                   dma_rsp_valid,
  output logic [FDATA_WIDTH-1:0] dma_rsp_data
);

  logic        dma_force;
  dccm_req_t   wr_req;
  dccm_owner_e rsp_owner_d;
  dccm_owner_e rsp_owner_q;

  // The counter is 3 bits wide; a larger AGE_MAX could never be reached and
  // would shows up as this named block in the elaborated hierarchy.
  if (AGE_MAX >= (1 << DCCM_ARB_AGE_W)) begin : g_age_max_out_of_range
  end

`ifdef LSU_DCCM_ARB_AGING_EN
  lsu_dccm_arb_age #(
    .AGE_MAX (AGE_MAX)
  ) u_age (
    .clk       (clk),
    .rst       (rst),
    .dma_req   (dma_req),
    .dma_gnt   (dma_gnt),
    .dma_force (dma_force)
  );
`else
  assign dma_force = 1'b0;
`endif

  // Grant selection: one-hot or zero, nothing while frozen or in reset.
  // A starving DMA (aged) wins outright; otherwise LSU first, and DMA jumps
  // ahead of SB unless the store buffer is full.
  always_comb begin
    lsu_rd_gnt = 1'b0;
    sb_wr_gnt  = 1'b0;
    dma_gnt    = 1'b0;
    if (!rst && !lsu_freeze_dc3) begin
      if (dma_force && dma_req) begin
        dma_gnt = 1'b1;
      end else if (lsu_rd_req) begin
        lsu_rd_gnt = 1'b1;
      end else if (dma_req && !sb_full) begin
        dma_gnt = 1'b1;
      end else if (sb_wr_req) begin
        sb_wr_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Memory port drive for the granted access; idle fields are zero.
  always_comb begin
    dccm_rden       = 1'b0;
    dccm_rd_addr_lo = '0;
    dccm_rd_addr_hi = '0;
    wr_req          = '0;
    if (lsu_rd_gnt) begin
      dccm_rden       = 1'b1;
      dccm_rd_addr_lo = lsu_rd_addr_lo;
      dccm_rd_addr_hi = lsu_rd_addr_hi;
    end
    if (dma_gnt && !dma_write) begin
      dccm_rden       = 1'b1;
      dccm_rd_addr_lo = dma_addr;
      dccm_rd_addr_hi = dma_addr;
    end
    if (sb_wr_gnt) begin
      wr_req.addr  = DCCM_ARB_ADDR_W'(sb_wr_addr);
      wr_req.data  = DCCM_ARB_DATA_W'(sb_wr_data);
      wr_req.write = 1'b1;
    end
    if (dma_gnt && dma_write) begin
      wr_req.addr  = DCCM_ARB_ADDR_W'(dma_addr);
      wr_req.data  = DCCM_ARB_DATA_W'(dma_wr_data);
      wr_req.write = 1'b1;
    end
  end

  assign dccm_wren    = wr_req.write;
  assign dccm_wr_addr = DCCM_BITS'(wr_req.addr);
  assign dccm_wr_data = FDATA_WIDTH'(wr_req.data);

  // Owner of this cycle's read grant; writes never produce a response.
  always_comb begin
    rsp_owner_d = OWN_NONE;
    if (lsu_rd_gnt) begin
      rsp_owner_d = OWN_LSU;
    end else if (dma_gnt && !dma_write) begin
      rsp_owner_d = OWN_DMA;
    end
  end

  // Response owner register: one-cycle read latency, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_owner_q <= OWN_NONE;
    end else begin
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign lsu_rsp_valid   = (rsp_owner_q == OWN_LSU);
  assign dma_rsp_valid   = (rsp_owner_q == OWN_DMA);
  assign lsu_rsp_data_lo = lsu_rsp_valid ? dccm_rd_data_lo : '0;
  assign lsu_rsp_data_hi = lsu_rsp_valid ? dccm_rd_data_hi : '0;
  assign dma_rsp_data    = dma_rsp_valid ? dccm_rd_data_lo : '0;

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed testbench for lsu_dccm_arb. Inputs change 1ns after posedge,
// outputs are sampled on the negedge. Aging checks follow LSU_DCCM_ARB_AGING_EN.
module tb_lsu_dccm_arb;

  localparam int AW    = 16;
  localparam int DW    = 39;
  localparam int OUT_W = 211;

  logic          clk;
  logic          rst;
  logic          lsu_freeze_dc3;
  logic          lsu_rd_req;
  logic [AW-1:0] lsu_rd_addr_lo;
  logic [AW-1:0] lsu_rd_addr_hi;
  logic          lsu_rd_gnt;
  logic          sb_wr_req;
  logic          sb_full;
  logic [AW-1:0] sb_wr_addr;
  logic [DW-1:0] sb_wr_data;
  logic          sb_wr_gnt;
  logic          dma_req;
  logic          dma_write;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wr_data;
  logic          dma_gnt;
  logic          dccm_wren;
  logic          dccm_rden;
  logic [AW-1:0] dccm_wr_addr;
  logic [AW-1:0] dccm_rd_addr_lo;
  logic [AW-1:0] dccm_rd_addr_hi;
  logic [DW-1:0] dccm_wr_data;
  logic [DW-1:0] dccm_rd_data_lo;
  logic [DW-1:0] dccm_rd_data_hi;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rsp_data_lo;
  logic [DW-1:0] lsu_rsp_data_hi;
  logic          dma_rsp_valid;
  logic [DW-1:0] dma_rsp_data;

  logic [OUT_W-1:0] all_out;
  int n_tests;
  int n_fail;

  lsu_dccm_arb dut (
    .clk             (clk),
    .rst             (rst),
    .lsu_freeze_dc3  (lsu_freeze_dc3),
    .lsu_rd_req      (lsu_rd_req),
    .lsu_rd_addr_lo  (lsu_rd_addr_lo),
    .lsu_rd_addr_hi  (lsu_rd_addr_hi),
    .lsu_rd_gnt      (lsu_rd_gnt),
    .sb_wr_req       (sb_wr_req),
    .sb_full         (sb_full),
    .sb_wr_addr      (sb_wr_addr),
    .sb_wr_data      (sb_wr_data),
    .sb_wr_gnt       (sb_wr_gnt),
    .dma_req         (dma_req),
    .dma_write       (dma_write),
    .dma_addr        (dma_addr),
    .dma_wr_data     (dma_wr_data),
    .dma_gnt         (dma_gnt),
    .dccm_wren       (dccm_wren),
    .dccm_rden       (dccm_rden),
    .dccm_wr_addr    (dccm_wr_addr),
    .dccm_rd_addr_lo (dccm_rd_addr_lo),
    .dccm_rd_addr_hi (dccm_rd_addr_hi),
    .dccm_wr_data    (dccm_wr_data),
    .dccm_rd_data_lo (dccm_rd_data_lo),
    .dccm_rd_data_hi (dccm_rd_data_hi),
    .lsu_rsp_valid   (lsu_rsp_valid),
    .lsu_rsp_data_lo (lsu_rsp_data_lo),
    .lsu_rsp_data_hi (lsu_rsp_data_hi),
    .dma_rsp_valid   (dma_rsp_valid),
    .dma_rsp_data    (dma_rsp_data)
  );

  assign all_out = {lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_wren, dccm_rden,
                    dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data,
                    lsu_rsp_valid, lsu_rsp_data_lo, lsu_rsp_data_hi,
                    dma_rsp_valid, dma_rsp_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    lsu_rd_req = 1'b0;
    sb_wr_req  = 1'b0;
    sb_full    = 1'b0;
    dma_req    = 1'b0;
    dma_write  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    lsu_freeze_dc3 = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_idle: outputs got %h want 0", all_out); end
    lsu_rd_req = 1'b1; sb_wr_req = 1'b1; dma_req = 1'b1;
    @(negedge clk);
    n_tests++; if ({lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren} !== 5'b0) begin n_fail++; $display("FAIL reset_reqs: grants/enables got %b want 00000", {lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren}); end
    next_cycle();
    clear_reqs();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_release: outputs got %h want 0", all_out); end
    $display("[TB] reset: done");
  endtask

  task automatic test_lsu_read();
    next_cycle();
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0010; lsu_rd_addr_hi = 16'h0014;
    dccm_rd_data_lo = 39'h12345; dccm_rd_data_hi = 39'h6789A;
    @(negedge clk);
    n_tests++; if ({lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren} !== 5'b10010) begin n_fail++; $display("FAIL lsu_gnt: gnt/en got %b want 10010", {lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren}); end
    n_tests++; if ({dccm_rd_addr_lo, dccm_rd_addr_hi} !== {16'h0010, 16'h0014}) begin n_fail++; $display("FAIL lsu_addr: got %h/%h want 0010/0014", dccm_rd_addr_lo, dccm_rd_addr_hi); end
    n_tests++; if (lsu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lsu_rsp_early: valid got %b want 0", lsu_rsp_valid); end
    next_cycle();
    lsu_rd_req = 1'b0;
    @(negedge clk);
    n_tests++; if ({lsu_rsp_valid, lsu_rsp_data_lo, lsu_rsp_data_hi} !== {1'b1, 39'h12345, 39'h6789A}) begin n_fail++; $display("FAIL lsu_rsp: got v=%b lo=%h hi=%h want v=1 lo=12345 hi=6789a", lsu_rsp_valid, lsu_rsp_data_lo, lsu_rsp_data_hi); end
    n_tests++; if ({dma_rsp_valid, dma_rsp_data} !== {1'b0, 39'h0}) begin n_fail++; $display("FAIL lsu_rsp_dma_side: got v=%b d=%h want 0/0", dma_rsp_valid, dma_rsp_data); end
    next_cycle();
    @(negedge clk);
    n_tests++; if ({lsu_rsp_valid, lsu_rsp_data_lo} !== {1'b0, 39'h0}) begin n_fail++; $display("FAIL lsu_rsp_once: got v=%b lo=%h want 0/0", lsu_rsp_valid, lsu_rsp_data_lo); end
    $display("[TB] lsu_read: done");
  endtask

  task automatic test_priority_sb_full();
    next_cycle();
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0008; lsu_rd_addr_hi = 16'h000C;
    sb_wr_req = 1'b1; sb_full = 1'b1; sb_wr_addr = 16'h0020; sb_wr_data = 39'h0AAAA;
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0030;
    dccm_rd_data_lo = 39'h55AA1;
    @(negedge clk);
    n_tests++; if ({lsu_rd_gnt, sb_wr_gnt, dma_gnt} !== 3'b100) begin n_fail++; $display("FAIL prio_c0: gnt got %b want 100", {lsu_rd_gnt, sb_wr_gnt, dma_gnt}); end
    next_cycle();
    lsu_rd_req = 1'b0;
    @(negedge clk);
    n_tests++; if ({lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_wren, dccm_rden} !== 5'b01010) begin n_fail++; $display("FAIL prio_c1: gnt/en got %b want 01010", {lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_wren, dccm_rden}); end
    n_tests++; if ({dccm_wr_addr, dccm_wr_data} !== {16'h0020, 39'h0AAAA}) begin n_fail++; $display("FAIL prio_sb_wr: got %h/%h want 0020/0aaaa", dccm_wr_addr, dccm_wr_data); end
    n_tests++; if (lsu_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL prio_lsu_rsp: valid got %b want 1", lsu_rsp_valid); end
    next_cycle();
    sb_wr_req = 1'b0; sb_full = 1'b0;
    @(negedge clk);
    n_tests++; if ({lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren} !== 5'b00110) begin n_fail++; $display("FAIL prio_c2: gnt/en got %b want 00110", {lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren}); end
    n_tests++; if ({dccm_rd_addr_lo, dccm_rd_addr_hi} !== {16'h0030, 16'h0030}) begin n_fail++; $display("FAIL prio_dma_addr: got %h/%h want 0030/0030", dccm_rd_addr_lo, dccm_rd_addr_hi); end
    n_tests++; if ({lsu_rsp_valid, dma_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL prio_sb_no_rsp: valids got %b want 00", {lsu_rsp_valid, dma_rsp_valid}); end
    next_cycle();
    dma_req = 1'b0;
    @(negedge clk);
    n_tests++; if ({dma_rsp_valid, dma_rsp_data, lsu_rsp_valid} !== {1'b1, 39'h55AA1, 1'b0}) begin n_fail++; $display("FAIL prio_dma_rsp: got v=%b d=%h lsu_v=%b want 1/55aa1/0", dma_rsp_valid, dma_rsp_data, lsu_rsp_valid); end
    $display("[TB] priority_sb_full: done");
  endtask

  task automatic test_dma_over_sb();
    next_cycle();
    sb_wr_req = 1'b1; sb_full = 1'b0; sb_wr_addr = 16'h0044; sb_wr_data = 39'h01111;
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0050; dma_wr_data = 39'h02222;
    @(negedge clk);
    n_tests++; if ({lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_wren, dccm_rden} !== 5'b00110) begin n_fail++; $display("FAIL dma_sb_c0: gnt/en got %b want 00110", {lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_wren, dccm_rden}); end
    n_tests++; if ({dccm_wr_addr, dccm_wr_data} !== {16'h0050, 39'h02222}) begin n_fail++; $display("FAIL dma_wr: got %h/%h want 0050/02222", dccm_wr_addr, dccm_wr_data); end
    next_cycle();
    dma_req = 1'b0;
    @(negedge clk);
    n_tests++; if ({sb_wr_gnt, dma_gnt, dccm_wren, dccm_wr_addr} !== {3'b101, 16'h0044}) begin n_fail++; $display("FAIL dma_sb_c1: sb/dma/wren got %b addr %h want 101/0044", {sb_wr_gnt, dma_gnt, dccm_wren}, dccm_wr_addr); end
    n_tests++; if (dma_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dma_wr_no_rsp: valid got %b want 0", dma_rsp_valid); end
    next_cycle();
    clear_reqs();
    $display("[TB] dma_over_sb: done");
  endtask

  task automatic test_freeze();
    next_cycle();
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0060; lsu_rd_addr_hi = 16'h0064;
    @(negedge clk);
    n_tests++; if (lsu_rd_gnt !== 1'b1) begin n_fail++; $display("FAIL frz_pre: lsu_gnt got %b want 1", lsu_rd_gnt); end
    next_cycle();
    lsu_freeze_dc3 = 1'b1;
    sb_wr_req = 1'b1; sb_full = 1'b1; dma_req = 1'b1; dma_write = 1'b0;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      n_tests++; if ({lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren} !== 5'b0) begin n_fail++; $display("FAIL frz_%0d_gnt: gnt/en got %b want 00000", f, {lsu_rd_gnt, sb_wr_gnt, dma_gnt, dccm_rden, dccm_wren}); end
      n_tests++; if (lsu_rsp_valid !== (f == 0)) begin n_fail++; $display("FAIL frz_%0d_rsp: lsu_valid got %b want %b", f, lsu_rsp_valid, (f == 0)); end
      next_cycle();
    end
    lsu_freeze_dc3 = 1'b0;
    clear_reqs();
    @(negedge clk);
    n_tests++; if ({lsu_rsp_valid, dma_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL frz_post: valids got %b want 00", {lsu_rsp_valid, dma_rsp_valid}); end
    $display("[TB] freeze: done");
  endtask

  task automatic test_back_to_back();
    next_cycle();
    sb_wr_req = 1'b1; sb_full = 1'b1; sb_wr_addr = 16'h0070; sb_wr_data = 39'h03333;
    @(negedge clk);
    n_tests++; if ({sb_wr_gnt, dccm_wren, dccm_wr_addr} !== {2'b11, 16'h0070}) begin n_fail++; $display("FAIL b2b_wr: got %b addr %h want 11/0070", {sb_wr_gnt, dccm_wren}, dccm_wr_addr); end
    next_cycle();
    clear_reqs();
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0070; lsu_rd_addr_hi = 16'h0074;
    dccm_rd_data_lo = 39'h03333;
    @(negedge clk);
    n_tests++; if ({lsu_rd_gnt, dccm_rden, dccm_wren, dccm_rd_addr_lo, lsu_rsp_valid} !== {3'b110, 16'h0070, 1'b0}) begin n_fail++; $display("FAIL b2b_rd: gnt/rden/wren got %b addr %h rsp %b want 110/0070/0", {lsu_rd_gnt, dccm_rden, dccm_wren}, dccm_rd_addr_lo, lsu_rsp_valid); end
    next_cycle();
    @(negedge clk);
    n_tests++; if ({lsu_rsp_valid, lsu_rsp_data_lo} !== {1'b1, 39'h03333}) begin n_fail++; $display("FAIL b2b_rsp1: got v=%b lo=%h want 1/03333", lsu_rsp_valid, lsu_rsp_data_lo); end
    next_cycle();
    lsu_rd_req = 1'b0;
    @(negedge clk);
    n_tests++; if (lsu_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp2: valid got %b want 1", lsu_rsp_valid); end
    $display("[TB] back_to_back: done");
  endtask

  task automatic test_aging();
    bit exp_dma;
    bit exp_dma_rsp;
    next_cycle();
    rst = 1'b1;
    clear_reqs();
    next_cycle();
    rst = 1'b0;
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0080; lsu_rd_addr_hi = 16'h0084;
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0090;
    for (int c = 0; c < 12; c++) begin
`ifdef LSU_DCCM_ARB_AGING_EN
      exp_dma     = (c == 7);
      exp_dma_rsp = (c == 8);
`else
      exp_dma     = 1'b0;
      exp_dma_rsp = 1'b0;
`endif
      @(negedge clk);
      n_tests++; if ({lsu_rd_gnt, dma_gnt} !== {!exp_dma, exp_dma}) begin n_fail++; $display("FAIL age_c%0d: lsu/dma gnt got %b want %b", c, {lsu_rd_gnt, dma_gnt}, {!exp_dma, exp_dma}); end
      n_tests++; if (dma_rsp_valid !== exp_dma_rsp) begin n_fail++; $display("FAIL age_rsp_c%0d: dma_valid got %b want %b", c, dma_rsp_valid, exp_dma_rsp); end
      next_cycle();
      if (exp_dma) dma_req = 1'b0;
    end
    clear_reqs();
    $display("[TB] aging: done");
  endtask

  task automatic test_reset_mid_rsp();
    next_cycle();
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h00A0; lsu_rd_addr_hi = 16'h00A4;
    @(negedge clk);
    n_tests++; if (lsu_rd_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: lsu_gnt got %b want 1", lsu_rd_gnt); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    lsu_rd_req = 1'b0;
    @(negedge clk);
    n_tests++; if (lsu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp: lsu_valid got %b want 0", lsu_rsp_valid); end
    n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL rstmid_outs: outputs got %h want 0", all_out); end
    $display("[TB] reset_mid_rsp: done");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    lsu_freeze_dc3 = 1'b0;
    lsu_rd_req = 1'b0; lsu_rd_addr_lo = '0; lsu_rd_addr_hi = '0;
    sb_wr_req = 1'b0; sb_full = 1'b0; sb_wr_addr = '0; sb_wr_data = '0;
    dma_req = 1'b0; dma_write = 1'b0; dma_addr = '0; dma_wr_data = '0;
    dccm_rd_data_lo = 39'h12345; dccm_rd_data_hi = 39'h6789A;
    test_reset();
    test_lsu_read();
    test_priority_sb_full();
    test_dma_over_sb();
    test_freeze();
    test_back_to_back();
    test_aging();
    test_reset_mid_rsp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dccm_arb.md
Name: lsu_dccm_arb

Overview:
- Single-port arbiter and sequencer for the DCCM bank array. It sits between three requesters and the DCCM memory wrapper:
  - LSU DC1 load read (lo/hi addresses for misaligned accesses)
  - store-buffer write drain
  - DMA read/write
- Each cycle it grants at most one access, drives the memory control/address/data, and tags the one-cycle-latency read return to its owner.
- It honours the DC3 freeze and prevents DMA starvation.

Parameters:
- DCCM_BITS, 16, byte-address width of DCCM.
- FDATA_WIDTH, 39, bank data width including ECC.
- AGE_MAX, 7, DMA wait cycles before forced DMA priority (aging feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lsu_freeze_dc3  in  1  pipeline freeze; no grants while high
- lsu_rd_req  in  1  LSU load read request
- lsu_rd_addr_lo  in  DCCM_BITS  LSU read address, lo bank
- lsu_rd_addr_hi  in  DCCM_BITS  LSU read address, hi bank
- lsu_rd_gnt  out  1  LSU read granted this cycle
- sb_wr_req  in  1  store-buffer drain request
- sb_full  in  1  store buffer full; raises SB above DMA
- sb_wr_addr  in  DCCM_BITS  SB write address
- sb_wr_data  in  FDATA_WIDTH  SB write data
- sb_wr_gnt  out  1  SB write granted
- dma_req  in  1  DMA request; held until granted
- dma_write  in  1  1=write, 0=read
- dma_addr  in  DCCM_BITS  DMA address
- dma_wr_data  in  FDATA_WIDTH  DMA write data
- dma_gnt  out  1  DMA granted
- dccm_wren  out  1  to memory: write enable
- dccm_rden  out  1  to memory: read enable
- dccm_wr_addr  out  DCCM_BITS  to memory: write address
- dccm_rd_addr_lo  out  DCCM_BITS  to memory: read address, lo bank
- dccm_rd_addr_hi  out  DCCM_BITS  to memory: read address, hi bank
- dccm_wr_data  out  FDATA_WIDTH  to memory: write data
- dccm_rd_data_lo  in  FDATA_WIDTH  from memory: read data, lo bank
- dccm_rd_data_hi  in  FDATA_WIDTH  from memory: read data, hi bank
- lsu_rsp_valid  out  1  LSU read data valid
- lsu_rsp_data_lo  out  FDATA_WIDTH  LSU read data, lo bank
- lsu_rsp_data_hi  out  FDATA_WIDTH  LSU read data, hi bank
- dma_rsp_valid  out  1  DMA read data valid
- dma_rsp_data  out  FDATA_WIDTH  DMA read data (lo bank)

Behaviour:
- Grant logic is combinational and one-hot or zero. All grants are 0 when lsu_freeze_dc3=1.
- Base priority:
  - LSU read > SB write > DMA.
  - If sb_full=0 and dma_req=1: LSU > DMA > SB.
- Memory drive:
  - dccm_rden is asserted for an LSU grant or a DMA read grant.
  - dccm_wren is asserted for an SB grant or a DMA write grant.
  - For a DMA grant, dma_addr drives both rd_addr_lo and rd_addr_hi, or wr_addr.
  - Address/data outputs are don't-care when no enable is asserted; implementation drives 0.
- Response tracking: owner register rsp_owner_q (NONE/LSU/DMA) is a 2-bit flop.
  - Loaded every cycle with the owner of the current read grant, else NONE.
  - Reset value NONE.
- lsu_rsp_valid = (rsp_owner_q==LSU); dma_rsp_valid = (rsp_owner_q==DMA). Read latency is exactly 1 cycle after the grant.
- Response data passes through combinationally from dccm_rd_data_*. It is zero-gated when the corresponding valid is low.
- Freeze:
  - A response issued in the cycle freeze rises is still reported, because memory Q holds the captured data.
  - In the following cycle rsp_owner_q becomes NONE, since no grant was made.
- Simultaneous events:
  - Write grants never return a response.
  - A write in cycle N followed by a read of the same address in N+1 returns the new data; memory ordering is guaranteed by the single port.
- Reset values: all outputs 0 and rsp_owner_q=NONE. Reset mid-response discards the pending response.

Optional Feature:
- LSU_DCCM_ARB_AGING_EN defined:
  - A 3-bit saturating counter dma_age_q increments each cycle dma_req=1 and dma_gnt=0, and clears on dma_gnt or rst.
  - When dma_age_q==AGE_MAX, DMA takes highest priority over LSU and SB for one grant (freeze still blocks it). lsu_rd_gnt=0 that cycle.
- Undefined: no counter; DMA can be starved indefinitely by LSU.

Decomposition:
- Shared package holds:
  - typedef enum logic [1:0] dccm_owner_e {OWN_NONE, OWN_LSU, OWN_DMA}
  - typedef struct dccm_req_t {addr, data, write}
  - constant DCCM_ARB_AGE_W=3
- One sub-module is natural: lsu_dccm_arb_age (saturating counter plus force flag), instantiated only under the macro.

Test Plan:
- LSU read 0x0010 at cycle 0 with dccm_rd_data_lo=0x12345 -> lsu_rd_gnt=1, dccm_rden=1 in cycle 0; lsu_rsp_valid=1, lsu_rsp_data_lo=0x12345 in cycle 1 only.
- LSU read, SB write 0x0020 and DMA read all requested in the same cycle, sb_full=1 -> cycle0 LSU granted, cycle1 SB (dccm_wren=1, wr_addr=0x0020), cycle2 DMA; dma_rsp_valid in cycle3.
- SB and DMA requested with sb_full=0 -> DMA granted first, SB next cycle.
- lsu_freeze_dc3=1 for 3 cycles with all requests high -> no grants and dccm_rden=dccm_wren=0. A response from the cycle before the freeze is still seen in the first frozen cycle.
- Aging enabled, LSU requests every cycle, DMA held -> dma_gnt=1 in cycle 7 (age==7), lsu_rd_gnt=0 that cycle, age cleared. Without the macro, dma_gnt never asserts.
- rst asserted in the cycle after an LSU grant -> lsu_rsp_valid=0 and all outputs 0 in the following cycle.
